// File: rtl/baccarat_pkg.sv
// Shared types, constants and card arithmetic for the baccarat hand datapath.
package baccarat_pkg;

  localparam int unsigned CARD_W = 4;

  localparam logic [CARD_W-1:0] ACE  = 4'd1;
  localparam logic [CARD_W-1:0] KING = 4'd13;

  typedef enum logic [2:0] {
    StEmpty,
    StP1,
    StD1,
    StP2,
    StD2,
    StP3,
    StDone
  } seq_state_t;

  // Face value of a card code; tens, court cards and illegal codes are worth 0.
  function automatic logic [3:0] card_value(input logic [CARD_W-1:0] code);
    logic [3:0] v;
    v = 4'd0;
    if (code >= ACE && code <= 4'd9) v = code;
    return v;
  endfunction

  // Banker third-card decision. Without a player third card the banker draws on 0..5.
  function automatic logic banker_rule(input logic [3:0] dscore, input logic [3:0] t,
                                       input logic player_drew);
    logic draw;
    draw = 1'b0;
    if (!player_drew) begin
      draw = (dscore <= 4'd5);
    end else begin
      case (dscore)
        4'd0, 4'd1, 4'd2: draw = 1'b1;
        4'd3:             draw = (t != 4'd8);
        4'd4:             draw = (t >= 4'd2) && (t <= 4'd7);
        4'd5:             draw = (t >= 4'd4) && (t <= 4'd7);
        4'd6:             draw = (t >= 4'd6) && (t <= 4'd7);
        default:          draw = 1'b0;
      endcase
    end
    return draw;
  endfunction

endpackage

// File: rtl/baccarat_score.sv
// Combinational hand total: sum of three card values, modulo 10.
module baccarat_score
  import baccarat_pkg::*;
(
  input  logic [CARD_W-1:0] card1_i,
  input  logic [CARD_W-1:0] card2_i,
  input  logic [CARD_W-1:0] card3_i,
  output logic [3:0]        score_o
);

  logic [4:0] sum;

  always_comb begin
    sum = 5'(card_value(card1_i)) + 5'(card_value(card2_i)) + 5'(card_value(card3_i));
    // Sum never exceeds 27, so two conditional subtractions cover the modulo.
    if (sum >= 5'd20) begin
      score_o = 4'(sum - 5'd20);
    end else if (sum >= 5'd10) begin
      score_o = 4'(sum - 5'd10);
    end else begin
      score_o = sum[3:0];
    end
  end

endmodule

// File: rtl/baccarat_hand_datapath.sv
// Card slots, dealing-order sequencer, scoring and third-card rules for one baccarat hand.
module baccarat_hand_datapath
  import baccarat_pkg::*;
(
  input  logic              slow_clock,
  input  logic              resetb,
  input  logic [CARD_W-1:0] new_card,
  input  logic              load_pcard1,
  input  logic              load_pcard2,
  input  logic              load_pcard3,
  input  logic              load_dcard1,
  input  logic              load_dcard2,
  input  logic              load_dcard3,
  output logic [CARD_W-1:0] pcard1,
  output logic [CARD_W-1:0] pcard2,
  output logic [CARD_W-1:0] pcard3,
  output logic [CARD_W-1:0] dcard1,
  output logic [CARD_W-1:0] dcard2,
  output logic [CARD_W-1:0] dcard3,
  output logic [3:0]        pscore,
  output logic [3:0]        dscore,
  output logic              player_draws,
  output logic              banker_draws,
  output logic              hand_done,
  output logic              protocol_error
);

  seq_state_t state_q, state_d;
  logic [CARD_W-1:0] pcard1_q, pcard2_q, pcard3_q, dcard1_q, dcard2_q, dcard3_q;
  logic [CARD_W-1:0] pcard1_d, pcard2_d, pcard3_d, dcard1_d, dcard2_d, dcard3_d;
  logic err_q, err_d;

  logic [5:0] strb;
  logic       any_strb, multi_strb, legal, clear_hand, bad_code;

  assign strb = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
  assign any_strb   = |strb;
  assign multi_strb = (strb & (strb - 6'd1)) != 6'd0;
  assign bad_code   = (new_card == '0) || (new_card > KING);

  baccarat_score u_pscore (
    .card1_i (pcard1_q),
    .card2_i (pcard2_q),
    .card3_i (pcard3_q),
    .score_o (pscore)
  );

  baccarat_score u_dscore (
    .card1_i (dcard1_q),
    .card2_i (dcard2_q),
    .card3_i (dcard3_q),
    .score_o (dscore)
  );

  // Draw and done flags depend only on the sequencer state and the stored cards.
  always_comb begin
    player_draws = 1'b0;
    banker_draws = 1'b0;
    hand_done    = 1'b0;
    case (state_q)
      StD2: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) begin
          hand_done = 1'b1;
        end else if (pscore <= 4'd5) begin
          player_draws = 1'b1;
        end else begin
          banker_draws = banker_rule(dscore, 4'd0, 1'b0);
          hand_done    = !banker_draws;
        end
      end
      StP3: begin
        banker_draws = banker_rule(dscore, card_value(pcard3_q), 1'b1);
        hand_done    = !banker_draws;
      end
      StDone:  hand_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pcard1_d   = pcard1_q;
    pcard2_d   = pcard2_q;
    pcard3_d   = pcard3_q;
    dcard1_d   = dcard1_q;
    dcard2_d   = dcard2_q;
    dcard3_d   = dcard3_q;
    err_d      = err_q;
    legal      = 1'b0;
    clear_hand = 1'b0;

    case (state_q)
      StEmpty: if (load_pcard1) begin legal = 1'b1; state_d = StP1; end
      StP1:    if (load_dcard1) begin legal = 1'b1; state_d = StD1; end
      StD1:    if (load_pcard2) begin legal = 1'b1; state_d = StP2; end
      StP2:    if (load_dcard2) begin legal = 1'b1; state_d = StD2; end
      StD2: begin
        if (player_draws && load_pcard3) begin
          legal   = 1'b1;
          state_d = StP3;
        end else if (banker_draws && load_dcard3) begin
          legal   = 1'b1;
          state_d = StDone;
        end
      end
      StP3:    if (banker_draws && load_dcard3) begin legal = 1'b1; state_d = StDone; end
      default: ;
    endcase

    // A finished hand (including a natural or a stand resolved in D2/P3) behaves as DONE.
    if (hand_done && load_pcard1) begin
      legal      = 1'b1;
      clear_hand = 1'b1;
      state_d    = StP1;
    end

    if (any_strb) begin
      if (multi_strb || !legal) begin
        state_d = state_q;
        err_d   = 1'b1;
      end else begin
        if (clear_hand) begin
          pcard2_d = '0;
          pcard3_d = '0;
          dcard1_d = '0;
          dcard2_d = '0;
          dcard3_d = '0;
        end
        if (load_pcard1) pcard1_d = new_card;
        if (load_pcard2) pcard2_d = new_card;
        if (load_pcard3) pcard3_d = new_card;
        if (load_dcard1) dcard1_d = new_card;
        if (load_dcard2) dcard2_d = new_card;
        if (load_dcard3) dcard3_d = new_card;
        if (bad_code) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q  <= StEmpty;
      pcard1_q <= '0;
      pcard2_q <= '0;
      pcard3_q <= '0;
      dcard1_q <= '0;
      dcard2_q <= '0;
      dcard3_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcard1_q <= pcard1_d;
      pcard2_q <= pcard2_d;
      pcard3_q <= pcard3_d;
      dcard1_q <= dcard1_d;
      dcard2_q <= dcard2_d;
      dcard3_q <= dcard3_d;
      err_q    <= err_d;
    end
  end

  assign pcard1         = pcard1_q;
  assign pcard2         = pcard2_q;
  assign pcard3         = pcard3_q;
  assign dcard1         = dcard1_q;
  assign dcard2         = dcard2_q;
  assign dcard3         = dcard3_q;
  assign protocol_error = err_q;

endmodule

// File: tb/tb_baccarat_hand_datapath.sv
// Directed bench for baccarat_hand_datapath: dealing order, naturals, third-card rules, errors.
module tb_baccarat_hand_datapath;

  localparam logic [5:0] SP1 = 6'b000001;
  localparam logic [5:0] SP2 = 6'b000010;
  localparam logic [5:0] SP3 = 6'b000100;
  localparam logic [5:0] SD1 = 6'b001000;
  localparam logic [5:0] SD2 = 6'b010000;
  localparam logic [5:0] SD3 = 6'b100000;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b1;
  logic [3:0] new_card   = 4'd0;
  logic [5:0] strb       = 6'd0;

  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic       player_draws, banker_draws, hand_done, protocol_error;

  logic [11:0] status;
  logic [23:0] slots;

  int checks   = 0;
  int failures = 0;

  assign status = {pscore, dscore, player_draws, banker_draws, hand_done, protocol_error};
  assign slots  = {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3};

  always #5 slow_clock = ~slow_clock;

  baccarat_hand_datapath dut (
    .slow_clock     (slow_clock),
    .resetb         (resetb),
    .new_card       (new_card),
    .load_pcard1    (strb[0]),
    .load_pcard2    (strb[1]),
    .load_pcard3    (strb[2]),
    .load_dcard1    (strb[3]),
    .load_dcard2    (strb[4]),
    .load_dcard3    (strb[5]),
    .pcard1         (pcard1),
    .pcard2         (pcard2),
    .pcard3         (pcard3),
    .dcard1         (dcard1),
    .dcard2         (dcard2),
    .dcard3         (dcard3),
    .pscore         (pscore),
    .dscore         (dscore),
    .player_draws   (player_draws),
    .banker_draws   (banker_draws),
    .hand_done      (hand_done),
    .protocol_error (protocol_error)
  );

  task automatic apply(input logic [5:0] s, input logic [3:0] c);
    @(negedge slow_clock);
    strb     = s;
    new_card = c;
    @(posedge slow_clock);
    #1;
    strb     = 6'd0;
    new_card = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge slow_clock);
    resetb = 1'b0;
    @(posedge slow_clock);
    #1;
    resetb = 1'b1;
  endtask

  task automatic deal4(input logic [3:0] p1, input logic [3:0] d1, input logic [3:0] p2,
                       input logic [3:0] d2);
    apply(SP1, p1);
    apply(SD1, d1);
    apply(SP2, p2);
    apply(SD2, d2);
  endtask

  // Strobe coincident with reset must be ignored.
  task automatic test_reset();
    @(negedge slow_clock);
    resetb   = 1'b0;
    strb     = SP1;
    new_card = 4'd5;
    @(posedge slow_clock);
    #1;
    resetb   = 1'b1;
    strb     = 6'd0;
    new_card = 4'd0;
    checks++;
    if (slots !== 24'h0) begin
      failures++;
      $display("FAIL reset_slots got=%h exp=%h", slots, 24'h0);
    end
    checks++;
    if (status !== 12'h0) begin
      failures++;
      $display("FAIL reset_status got=%h exp=%h", status, 12'h0);
    end
  endtask

  task automatic test_stand();
    do_reset();
    apply(SP1, 4'd3);
    apply(SD1, 4'd2);
    apply(SP2, 4'd4);
    checks++;
    if (status !== {4'd7, 4'd2, 4'b0000}) begin
      failures++;
      $display("FAIL stand_p2 got=%h exp=%h", status, {4'd7, 4'd2, 4'b0000});
    end
    apply(SD2, 4'd5);
    checks++;
    if (status !== {4'd7, 4'd7, 4'b0010}) begin
      failures++;
      $display("FAIL stand_d2 got=%h exp=%h", status, {4'd7, 4'd7, 4'b0010});
    end
    apply(6'd0, 4'd9);
    checks++;
    if (slots !== {4'd3, 4'd4, 4'd0, 4'd2, 4'd5, 4'd0}) begin
      failures++;
      $display("FAIL stand_hold got=%h exp=%h", slots, {4'd3, 4'd4, 4'd0, 4'd2, 4'd5, 4'd0});
    end
  endtask

  task automatic test_natural();
    do_reset();
    deal4(4'd9, 4'd2, 4'd13, 4'd3);
    checks++;
    if (status !== {4'd9, 4'd5, 4'b0010}) begin
      failures++;
      $display("FAIL natural_d2 got=%h exp=%h", status, {4'd9, 4'd5, 4'b0010});
    end
    apply(SP3, 4'd5);
    checks++;
    if (status !== {4'd9, 4'd5, 4'b0011}) begin
      failures++;
      $display("FAIL natural_p3_err got=%h exp=%h", status, {4'd9, 4'd5, 4'b0011});
    end
    checks++;
    if (slots !== {4'd9, 4'd13, 4'd0, 4'd2, 4'd3, 4'd0}) begin
      failures++;
      $display("FAIL natural_slots got=%h exp=%h", slots, {4'd9, 4'd13, 4'd0, 4'd2, 4'd3, 4'd0});
    end
  endtask

  task automatic test_player_third();
    do_reset();
    deal4(4'd1, 4'd10, 4'd2, 4'd3);
    checks++;
    if (status !== {4'd3, 4'd3, 4'b1000}) begin
      failures++;
      $display("FAIL pthird_d2 got=%h exp=%h", status, {4'd3, 4'd3, 4'b1000});
    end
    apply(SP3, 4'd8);
    checks++;
    if (status !== {4'd1, 4'd3, 4'b0010}) begin
      failures++;
      $display("FAIL pthird_p3 got=%h exp=%h", status, {4'd1, 4'd3, 4'b0010});
    end
    apply(SD3, 4'd5);
    checks++;
    if (status !== {4'd1, 4'd3, 4'b0011}) begin
      failures++;
      $display("FAIL pthird_d3_err got=%h exp=%h", status, {4'd1, 4'd3, 4'b0011});
    end
    checks++;
    if (slots !== {4'd1, 4'd2, 4'd8, 4'd10, 4'd3, 4'd0}) begin
      failures++;
      $display("FAIL pthird_slots got=%h exp=%h", slots, {4'd1, 4'd2, 4'd8, 4'd10, 4'd3, 4'd0});
    end
  endtask

  task automatic test_banker_third();
    do_reset();
    deal4(4'd2, 4'd4, 4'd2, 4'd1);
    checks++;
    if (status !== {4'd4, 4'd5, 4'b1000}) begin
      failures++;
      $display("FAIL bthird_d2 got=%h exp=%h", status, {4'd4, 4'd5, 4'b1000});
    end
    apply(SP3, 4'd6);
    checks++;
    if (status !== {4'd0, 4'd5, 4'b0100}) begin
      failures++;
      $display("FAIL bthird_p3 got=%h exp=%h", status, {4'd0, 4'd5, 4'b0100});
    end
    apply(SD3, 4'd12);
    checks++;
    if (status !== {4'd0, 4'd5, 4'b0010}) begin
      failures++;
      $display("FAIL bthird_done got=%h exp=%h", status, {4'd0, 4'd5, 4'b0010});
    end
    checks++;
    if (slots !== {4'd2, 4'd2, 4'd6, 4'd4, 4'd1, 4'd12}) begin
      failures++;
      $display("FAIL bthird_slots got=%h exp=%h", slots, {4'd2, 4'd2, 4'd6, 4'd4, 4'd1, 4'd12});
    end
  endtask

  // Continues from the DONE state left by test_banker_third.
  task automatic test_new_hand();
    apply(SP1, 4'd7);
    checks++;
    if (slots !== {4'd7, 20'h0}) begin
      failures++;
      $display("FAIL newhand_slots got=%h exp=%h", slots, {4'd7, 20'h0});
    end
    checks++;
    if (status !== {4'd7, 4'd0, 4'b0000}) begin
      failures++;
      $display("FAIL newhand_status got=%h exp=%h", status, {4'd7, 4'd0, 4'b0000});
    end
    apply(SD1, 4'd3);
    checks++;
    if (status !== {4'd7, 4'd3, 4'b0000}) begin
      failures++;
      $display("FAIL newhand_d1 got=%h exp=%h", status, {4'd7, 4'd3, 4'b0000});
    end
    do_reset();
    checks++;
    if (slots !== 24'h0) begin
      failures++;
      $display("FAIL midhand_reset_slots got=%h exp=%h", slots, 24'h0);
    end
  endtask

  task automatic test_errors();
    do_reset();
    apply(SD1, 4'd4);
    checks++;
    if (status !== {4'd0, 4'd0, 4'b0001}) begin
      failures++;
      $display("FAIL err_empty_d1 got=%h exp=%h", status, {4'd0, 4'd0, 4'b0001});
    end
    checks++;
    if (slots !== 24'h0) begin
      failures++;
      $display("FAIL err_empty_slots got=%h exp=%h", slots, 24'h0);
    end
    apply(SP1, 4'd7);
    apply(SP1 | SD1, 4'd2);
    checks++;
    if (slots !== {4'd7, 20'h0}) begin
      failures++;
      $display("FAIL err_multi_slots got=%h exp=%h", slots, {4'd7, 20'h0});
    end
    do_reset();
    checks++;
    if (status !== 12'h0) begin
      failures++;
      $display("FAIL err_reset_clear got=%h exp=%h", status, 12'h0);
    end
    apply(SP1, 4'd14);
    checks++;
    if ({slots, status} !== {4'd14, 20'h0, 4'd0, 4'd0, 4'b0001}) begin
      failures++;
      $display("FAIL err_bad_code got=%h exp=%h", {slots, status},
               {4'd14, 20'h0, 4'd0, 4'd0, 4'b0001});
    end
    apply(SD1, 4'd9);
    checks++;
    if (status !== {4'd0, 4'd9, 4'b0001}) begin
      failures++;
      $display("FAIL err_bad_code_advance got=%h exp=%h", status, {4'd0, 4'd9, 4'b0001});
    end
  endtask

  initial begin
    test_reset();
    test_stand();
    test_natural();
    test_player_third();
    test_banker_third();
    test_new_hand();
    test_errors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/baccarat_hand_datapath.md
Name: baccarat_hand_datapath

Overview:
Card-holding datapath on the receiving end of the round controller's load strobes.
- Captures the dealt card into the slot named by each load_* strobe.
- Tracks dealing order with its own sequencer.
- Computes player and banker scores.
- Evaluates the third-card rules and returns pscore, dscore and pcard3 to the controller.
- Flags strobe sequences that violate the dealing protocol.

Parameters:
CARD_W, 4, width of card code (1=A .. 10=10, 11=J, 12=Q, 13=K)

Ports:
slow_clock  input  1  clock, all state updates on rising edge
resetb  input  1  reset, synchronous, active-low
new_card  input  CARD_W  card code presented by the card source, sampled on a strobe edge
load_pcard1, load_pcard2, load_pcard3  input  1 each  capture new_card into player slot 1/2/3
load_dcard1, load_dcard2, load_dcard3  input  1 each  capture new_card into banker slot 1/2/3
pcard1, pcard2, pcard3  output  CARD_W each  stored player cards, 0 = slot empty
dcard1, dcard2, dcard3  output  CARD_W each  stored banker cards, 0 = slot empty
pscore, dscore  output  4 each  hand totals, 0..9
player_draws  output  1  player third card required
banker_draws  output  1  banker third card required
hand_done  output  1  no further cards required for this hand
protocol_error  output  1  sticky, illegal strobe or card code seen since reset

Behaviour:
Reset:
- When resetb=0 at an edge, all card registers go to 0, the sequencer goes to EMPTY and protocol_error goes to 0.
- Consequently pscore=dscore=0, player_draws=banker_draws=hand_done=0.

Card value and score arithmetic:
- Card value: codes 1..9 map to their face value; codes 10..13 map to 0.
- Illegal code (0, 14, 15) on a legal strobe: the code is still stored, its value is 0, and protocol_error is set.
- Scores: sum of the three slot values, taken mod 10. Empty slots contribute 0.
- Scores are combinational from the card registers, so they are valid in the cycle after the capturing edge (latency 1 edge).

Sequencer states: EMPTY, P1, D1, P2, D2, P3, DONE.
- EMPTY: only load_pcard1 is legal -> P1.
- P1: load_dcard1 -> D1.
- D1: load_pcard2 -> P2.
- P2: load_dcard2 -> D2.
- D2, natural (pscore or dscore is 8 or 9 after two cards each): -> DONE combinationally. hand_done=1, both draw flags 0.
- D2, player_draws=1 (pscore 0..5): only load_pcard3 is legal -> P3.
- D2, player stands (6..7): banker_draws=1 iff dscore 0..5. If banker_draws, load_dcard3 -> DONE; otherwise hand_done=1 immediately.
- P3: let t = value of pcard3. banker_draws follows the standard tableau:
  - dscore 0..2: draw
  - dscore 3: draw unless t=8
  - dscore 4: draw if t in 2..7
  - dscore 5: draw if t in 4..7
  - dscore 6: draw if t in 6..7
  - dscore 7: stand
  - If banker_draws, load_dcard3 -> DONE; otherwise hand_done=1 while in P3.
- DONE: hand_done=1. load_pcard1 starts a new hand: clears all slots, stores new_card in pcard1, goes to P1 in one edge.
- hand_done is also 1 in P3/D2 whenever no further card is required.

Flag outputs:
- player_draws is asserted only in D2.
- banker_draws is asserted only in D2 or P3.

Protocol errors (all set protocol_error, no card stored, state unchanged):
- A strobe that is not legal for the current state.
- Two or more strobes high in the same cycle.
- Any strobe while hand_done=1, except load_pcard1 in DONE.
- protocol_error clears only on reset.

Other boundary rules:
- Reset mid-hand discards all cards.
- No strobe = hold all state.
- A strobe coincident with reset is ignored.

Decomposition:
- Shared package baccarat_pkg:
  - seq_state_t enum (EMPTY..DONE)
  - CARD_W
  - card code constants (ACE=1, KING=13)
  - function card_value(code) -> 0..9
  - function banker_rule(dscore, t, player_drew) -> bit
- Sub-module: baccarat_score (combinational, three card codes -> mod-10 total), instantiated twice. Sequencer and registers stay in the top.

Test Plan:
- Reset, then strobes P1..D2 with new_card 3,2,4,5 -> pscore=7, dscore=7, player_draws=0, banker_draws=0, hand_done=1 after D2 edge.
- Cards P:9,K D:2,3 -> natural, pscore=9, dscore=5, hand_done=1 after D2; a following load_pcard3 sets protocol_error, pcard3 stays 0.
- Cards P:A,2 D:10,3, then pcard3=8 -> pscore=1, dscore=3, banker_draws=0, hand_done=1 in P3; then dcard3 strobe -> protocol_error=1.
- Cards P:2,2 D:4,A, pcard3=6, dcard3=Q -> banker_draws=1 in P3; final pscore=0, dscore=5, hand_done=1.
- load_dcard1 while EMPTY, and load_pcard1+load_dcard1 together in P1 -> protocol_error=1, all slots unchanged; reset -> protocol_error=0, all outputs 0.
- From DONE, load_pcard1 with new_card=7 -> pcard1=7, all other slots 0, pscore=7, state P1; resetb=0 mid-hand at D1 -> all slots 0 next edge.
